// File: rtl/float_pkg.sv
// float_pkg: shared half-precision format constants for the float datapath
package float_pkg;
    localparam int FP_EXP_W = 5;
    localparam int FP_MAN_W = 10;
    localparam int FP_W = 1 + FP_EXP_W + FP_MAN_W;
    localparam int FP_BIAS = (1 << (FP_EXP_W - 1)) - 1;
endpackage

// File: rtl/float_lzc.sv
// float_lzc: leading-zero counter, returns N for an all-zero input
module float_lzc #(
    parameter int N = 12,
    parameter int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]  x,
    output logic [CW-1:0] cnt
);
    always_comb begin
        cnt = CW'(N);
        for (int i = 0; i < N; i++)
            if (x[i]) cnt = CW'(N - 1 - i);
    end
endmodule

// File: rtl/float_add_pipe.sv
// float_add_pipe: 3-stage truncating float adder/subtractor with valid/ready flow
module float_add_pipe
    import float_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         op_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         ovf,
    output logic         unf
);
    localparam int F = MAN_W + 2;
    localparam int EW = EXP_W + 2;
    localparam int LZ_W = $clog2(F + 1);
    localparam logic signed [EW-1:0] E_MAX = EW'((1 << EXP_W) - 1);

    logic adv;
    assign adv = !out_valid || out_ready;
    assign in_ready = adv;

    logic sa, sb, za, zb, a_big;
    logic [EXP_W-1:0] ea, eb, diff;
    logic [MAN_W:0] big_f, sml_f, sml_al;
    assign sa = op_a[W-1];
    assign sb = op_b[W-1] ^ op_sub;
    assign ea = op_a[W-2:MAN_W];
    assign eb = op_b[W-2:MAN_W];
    assign za = ea == '0;
    assign zb = eb == '0;
    assign a_big = op_a[W-2:0] >= op_b[W-2:0];
    assign big_f = {1'b1, a_big ? op_a[MAN_W-1:0] : op_b[MAN_W-1:0]};
    assign sml_f = {1'b1, a_big ? op_b[MAN_W-1:0] : op_a[MAN_W-1:0]};
    assign diff = a_big ? ea - eb : eb - ea;
    assign sml_al = int'(diff) >= F ? '0 : sml_f >> diff;

    logic v1, s1_byp, s1_sign, s1_sub;
    logic [W-1:0] s1_byp_val;
    logic [EXP_W-1:0] s1_exp;
    logic [MAN_W:0] s1_big, s1_sml;

    logic v2, s2_byp, s2_sign;
    logic [W-1:0] s2_byp_val;
    logic [EXP_W-1:0] s2_exp;
    logic [F-1:0] s2_sum;

    logic [LZ_W-1:0] lz;
    logic signed [EW-1:0] e;
    logic [MAN_W-1:0] mant;
    logic [W-1:0] r_nxt;
    logic o_nxt, u_nxt, nz;

    float_lzc #(.N(F)) u_lzc (.x(s2_sum), .cnt(lz));

    // carry keeps the leading one at bit F-1; otherwise it is moved back to bit MAN_W
    assign e = s2_sum[F-1] ? EW'(s2_exp) + EW'(1) : EW'(s2_exp) - EW'(lz) + EW'(1);
    assign mant = s2_sum[F-1] ? s2_sum[MAN_W:1] : MAN_W'(s2_sum << (lz - LZ_W'(1)));
    assign nz = !s2_byp && s2_sum != '0;
    assign o_nxt = nz && e >= E_MAX;
    assign u_nxt = nz && e <= 0;
    assign r_nxt = s2_byp ? s2_byp_val
                 : (!nz || u_nxt) ? '0
                 : o_nxt ? {s2_sign, {{(EXP_W-1){1'b1}}, 1'b0}, {MAN_W{1'b1}}}
                 : {s2_sign, e[EXP_W-1:0], mant};

    always_ff @(posedge clk) begin
        if (reset) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            out_valid <= 1'b0;
            result <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (adv) begin
            v1 <= in_valid;
            s1_byp <= za || zb;
            s1_byp_val <= (za && zb) ? '0 : za ? {sb, op_b[W-2:0]} : op_a;
            s1_sign <= a_big ? sa : sb;
            s1_sub <= sa ^ sb;
            s1_exp <= a_big ? ea : eb;
            s1_big <= big_f;
            s1_sml <= sml_al;
            v2 <= v1;
            s2_byp <= s1_byp;
            s2_byp_val <= s1_byp_val;
            s2_sign <= s1_sign;
            s2_exp <= s1_exp;
            s2_sum <= s1_sub ? {1'b0, s1_big} - {1'b0, s1_sml} : {1'b0, s1_big} + {1'b0, s1_sml};
            out_valid <= v2;
            result <= r_nxt;
            ovf <= o_nxt;
            unf <= u_nxt;
        end
    end
endmodule

// File: tb/tb_float_add_pipe.sv
// tb_float_add_pipe: directed checks of float_add_pipe arithmetic, flow control and reset
module tb_float_add_pipe;
    logic clk = 0, reset = 1, in_valid = 0, op_sub = 0, out_ready = 1;
    logic in_ready, out_valid, ovf, unf;
    logic [15:0] op_a = '0, op_b = '0, result;
    int checks = 0, passed = 0;

    always #5 clk = ~clk;

    float_add_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_sub(op_sub), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .ovf(ovf), .unf(unf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic one_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic [15:0] er, input logic eo, input logic eu);
        int n;
        @(negedge clk);
        op_a = a;
        op_b = b;
        op_sub = sub;
        in_valid = 1;
        #1 chk({tag, " in_ready"}, 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, 32'(n), 3);
        chk({tag, " result"}, 32'(result), 32'(er));
        chk({tag, " ovf"}, 32'(ovf), 32'(eo));
        chk({tag, " unf"}, 32'(unf), 32'(eu));
    endtask

    initial begin
        logic [15:0] expq[$];
        logic [15:0] held;
        logic was_stall;
        int sent, got, seen;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst result", 32'(result), 0);
        chk("rst ovf", 32'(ovf), 0);
        chk("rst unf", 32'(unf), 0);
        reset = 0;
        #1 chk("rst in_ready", 32'(in_ready), 1);

        one_op("one_plus_one", 16'h3C00, 16'h3C00, 0, 16'h4000, 0, 0);
        one_op("sub_1p5_1", 16'h3E00, 16'h3C00, 1, 16'h3800, 0, 0);
        one_op("cancel", 16'h3C00, 16'hBC00, 0, 16'h0000, 0, 0);
        one_op("overflow", 16'h7BFF, 16'h7BFF, 0, 16'h7BFF, 1, 0);
        one_op("underflow", 16'h0401, 16'h8400, 0, 16'h0000, 0, 1);
        one_op("zero_a", 16'h0000, 16'hC500, 0, 16'hC500, 0, 0);
        one_op("far_align", 16'h3C00, 16'h0C00, 0, 16'h3C00, 0, 0);
        one_op("sub_zero_a", 16'h8000, 16'h4000, 1, 16'hC000, 0, 0);

        sent = 0;
        got = 0;
        was_stall = 0;
        held = '0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 5 && cyc < 9);
            in_valid = sent < 8;
            op_a = 16'h3C00 | 16'(sent * 8);
            op_b = 16'h3C00;
            op_sub = 0;
            #1;
            if (!out_ready && out_valid) begin
                chk("stall in_ready", 32'(in_ready), 0);
                if (was_stall) chk("stall hold", 32'(result), 32'(held));
                held = result;
                was_stall = 1;
            end else was_stall = 0;
            if (in_valid && in_ready) begin
                expq.push_back(16'h4000 | 16'(sent * 4));
                sent++;
            end
            if (out_valid && out_ready) begin
                chk("stream result", 32'(result), expq.size() > 0 ? 32'(expq.pop_front()) : 32'hFFFF);
                got++;
            end
        end
        chk("stream sent", 32'(sent), 8);
        chk("stream got", 32'(got), 8);
        chk("stream leftover", 32'(expq.size()), 0);

        @(negedge clk);
        in_valid = 0;
        out_ready = 0;
        op_a = 16'h3C00;
        op_b = 16'h3C00;
        @(negedge clk);
        in_valid = 1;
        repeat (3) @(negedge clk);
        in_valid = 0;
        chk("flight out_valid", 32'(out_valid), 1);
        reset = 1;
        @(negedge clk);
        chk("midrst out_valid", 32'(out_valid), 0);
        chk("midrst result", 32'(result), 0);
        reset = 0;
        out_ready = 1;
        #1 chk("midrst in_ready", 32'(in_ready), 1);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("no stale result", 32'(seen), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
